// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter and its ALU result FIFO.
package wb_pkg;

    localparam int unsigned WB_AWIDTH_DEFAULT     = 3;
    localparam int unsigned WB_DWIDTH_DEFAULT     = 8;
    localparam int unsigned WB_FIFO_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [WB_AWIDTH_DEFAULT-1:0] rd;
        logic [WB_DWIDTH_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO buffering ALU writeback results.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(wb_entry_t),
    parameter int unsigned DEPTH = WB_FIFO_DEPTH_DEFAULT,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_wdata;
    end

    always_comb begin
        w_count_nxt = r_count;
        if (i_push && !i_pop) w_count_nxt = r_count + 1'b1;
        if (i_pop && !i_push) w_count_nxt = r_count - 1'b1;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: LSU results take priority, ALU results queue in a FIFO.
// Define WB_BYPASS_EN to add register-read forwarding ports around the write port.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned AWIDTH     = WB_AWIDTH_DEFAULT,
    parameter int unsigned DWIDTH     = WB_DWIDTH_DEFAULT,
    parameter int unsigned FIFO_DEPTH = WB_FIFO_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [AWIDTH-1:0] alu_rd,
    input  logic [DWIDTH-1:0] alu_result,
    input  logic              lsu_valid,
    input  logic [AWIDTH-1:0] lsu_rd,
    input  logic [DWIDTH-1:0] lsu_data,
    output logic [DWIDTH-1:0] wdata,
    output logic [AWIDTH-1:0] waddr,
    output logic              wen,
    output logic              idle
`ifdef WB_BYPASS_EN
    ,
    input  logic [AWIDTH-1:0] raddr1,
    input  logic [AWIDTH-1:0] raddr2,
    input  logic [DWIDTH-1:0] rf_rdata1,
    input  logic [DWIDTH-1:0] rf_rdata2,
    output logic [DWIDTH-1:0] fwd_rdata1,
    output logic [DWIDTH-1:0] fwd_rdata2
`endif
);

    localparam int unsigned EW = AWIDTH + DWIDTH;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic              r_wen;
    logic [AWIDTH-1:0] r_waddr;
    logic [DWIDTH-1:0] r_wdata;
    logic              w_wen_nxt;
    logic [AWIDTH-1:0] w_waddr_nxt;
    logic [DWIDTH-1:0] w_wdata_nxt;

    logic              w_push;
    logic              w_pop;
    logic [EW-1:0]     w_head;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic              w_lsu_win;
    logic              w_alu_acc;
    logic              w_bypass;

    wb_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_alu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({alu_rd, alu_result}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // x0 writes are accepted (ready still applies) but never reach the FIFO or the port.
    assign alu_ready = !w_full;
    assign w_alu_acc = alu_valid && alu_ready && (alu_rd != '0);
    assign w_lsu_win = lsu_valid && (lsu_rd != '0);
    assign w_pop     = !w_lsu_win && !w_empty;
    assign w_bypass  = !w_lsu_win && w_empty && w_alu_acc;
    assign w_push    = w_alu_acc && !w_bypass;

    always_comb begin
        w_wen_nxt   = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        if (w_lsu_win) begin
            w_wen_nxt   = 1'b1;
            w_waddr_nxt = lsu_rd;
            w_wdata_nxt = lsu_data;
        end else if (!w_empty) begin
            w_wen_nxt   = 1'b1;
            w_waddr_nxt = w_head[EW-1:DWIDTH];
            w_wdata_nxt = w_head[DWIDTH-1:0];
        end else if (w_bypass) begin
            w_wen_nxt   = 1'b1;
            w_waddr_nxt = alu_rd;
            w_wdata_nxt = alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen   <= w_wen_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign wen   = r_wen;
    assign waddr = r_waddr;
    assign wdata = r_wdata;
    assign idle  = (w_count == '0) && !r_wen;

`ifdef WB_BYPASS_EN
    // Hides the register bank's write-then-read hazard on the same edge.
    assign fwd_rdata1 = (r_wen && (r_waddr == raddr1) && (raddr1 != '0)) ? r_wdata : rf_rdata1;
    assign fwd_rdata2 = (r_wen && (r_waddr == raddr2) && (raddr2 != '0)) ? r_wdata : rf_rdata2;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (optionally with WB_BYPASS_EN).
module tb_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_valid;
    logic       alu_ready;
    logic [2:0] alu_rd;
    logic [7:0] alu_result;
    logic       lsu_valid;
    logic [2:0] lsu_rd;
    logic [7:0] lsu_data;
    logic [7:0] wdata;
    logic [2:0] waddr;
    logic       wen;
    logic       idle;
`ifdef WB_BYPASS_EN
    logic [2:0] raddr1, raddr2;
    logic [7:0] rf_rdata1, rf_rdata2, fwd_rdata1, fwd_rdata2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .AWIDTH     (3),
        .DWIDTH     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_result (alu_result),
        .lsu_valid  (lsu_valid),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .wdata      (wdata),
        .waddr      (waddr),
        .wen        (wen),
        .idle       (idle)
`ifdef WB_BYPASS_EN
        ,
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .fwd_rdata1 (fwd_rdata1),
        .fwd_rdata2 (fwd_rdata2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        rst_n      = 1'b0;
        alu_valid  = 1'b0;
        alu_rd     = '0;
        alu_result = '0;
        lsu_valid  = 1'b0;
        lsu_rd     = '0;
        lsu_data   = '0;
`ifdef WB_BYPASS_EN
        raddr1 = '0; raddr2 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
`endif
        #12;
        check("rst_wen",   32'(wen),       0);
        check("rst_waddr", 32'(waddr),     0);
        check("rst_wdata", 32'(wdata),     0);
        check("rst_idle",  32'(idle),      1);
        check("rst_ready", 32'(alu_ready), 1);
        rst_n = 1'b1;
        step();

        // ALU bypass on empty FIFO
        alu_valid = 1'b1; alu_rd = 3'd3; alu_result = 8'h5A;
        step();
        alu_valid = 1'b0;
        check("byp_wen",   32'(wen),   1);
        check("byp_waddr", 32'(waddr), 3);
        check("byp_wdata", 32'(wdata), 32'h5A);
        check("byp_idle",  32'(idle),  0);
        step();
        check("byp_wen_off", 32'(wen),  0);
        check("byp_idle_on", 32'(idle), 1);

        // LSU wins, ALU result queued behind it
        lsu_valid = 1'b1; lsu_rd = 3'd2; lsu_data = 8'h11;
        alu_valid = 1'b1; alu_rd = 3'd5; alu_result = 8'h22;
        step();
        lsu_valid = 1'b0; alu_valid = 1'b0;
        check("mix1_waddr", 32'(waddr), 2);
        check("mix1_wdata", 32'(wdata), 32'h11);
        step();
        check("mix2_wen",   32'(wen),   1);
        check("mix2_waddr", 32'(waddr), 5);
        check("mix2_wdata", 32'(wdata), 32'h22);
        step();
        check("mix3_wen", 32'(wen), 0);

        // LSU streams for 6 cycles; ALU fills the FIFO and stalls
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            lsu_valid = 1'b1; lsu_rd = 3'(i + 1); lsu_data = 8'(8'h40 + i);
            alu_valid = 1'b1; alu_rd = 3'd6; alu_result = 8'(8'h30 + acc);
            #1;
            check($sformatf("fill_ready%0d", i), 32'(alu_ready), (i < 4) ? 1 : 0);
            if (i < 4) acc++;
            step();
            check($sformatf("fill_waddr%0d", i), 32'(waddr), i + 1);
            check($sformatf("fill_wdata%0d", i), 32'(wdata), 32'h40 + i);
        end
        lsu_valid = 1'b0; alu_valid = 1'b0;
        #1;
        check("full_ready", 32'(alu_ready), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("drain_wen%0d", k),   32'(wen),   1);
            check($sformatf("drain_waddr%0d", k), 32'(waddr), 6);
            check($sformatf("drain_wdata%0d", k), 32'(wdata), 32'h30 + k);
            check($sformatf("drain_ready%0d", k), 32'(alu_ready), 1);
        end
        step();
        check("drain_end_wen",  32'(wen),  0);
        check("drain_end_idle", 32'(idle), 1);

        // x0 destinations are swallowed
        lsu_valid = 1'b1; lsu_rd = 3'd0; lsu_data = 8'hEE;
        alu_valid = 1'b1; alu_rd = 3'd0; alu_result = 8'hDD;
        #1;
        check("x0_ready_pre", 32'(alu_ready), 1);
        step();
        lsu_valid = 1'b0; alu_valid = 1'b0;
        check("x0_wen",   32'(wen),       0);
        check("x0_idle",  32'(idle),      1);
        check("x0_ready", 32'(alu_ready), 1);
        step();
        check("x0_wen2",  32'(wen),  0);
        check("x0_idle2", 32'(idle), 1);

        // Fill 3 entries, then reset mid-cycle
        for (int i = 0; i < 3; i++) begin
            lsu_valid = 1'b1; lsu_rd = 3'd1; lsu_data = 8'h55;
            alu_valid = 1'b1; alu_rd = 3'd7; alu_result = 8'(8'h70 + i);
            step();
        end
        lsu_valid = 1'b0; alu_valid = 1'b0;
        check("pre_rst_wen", 32'(wen), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wen",   32'(wen),       0);
        check("mid_rst_idle",  32'(idle),      1);
        check("mid_rst_ready", 32'(alu_ready), 1);
        step();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("post_rst_wen%0d", k),  32'(wen),  0);
            check($sformatf("post_rst_idle%0d", k), 32'(idle), 1);
        end

`ifdef WB_BYPASS_EN
        alu_valid = 1'b1; alu_rd = 3'd4; alu_result = 8'hAB;
        step();
        alu_valid = 1'b0;
        raddr1 = 3'd4; rf_rdata1 = 8'h00;
        raddr2 = 3'd3; rf_rdata2 = 8'h3C;
        #1;
        check("fwd1_hit",  32'(fwd_rdata1), 32'hAB);
        check("fwd2_miss", 32'(fwd_rdata2), 32'h3C);
        raddr1 = 3'd0; rf_rdata1 = 8'h99;
        raddr2 = 3'd4;
        #1;
        check("fwd1_x0",  32'(fwd_rdata1), 32'h99);
        check("fwd2_hit", 32'(fwd_rdata2), 32'hAB);
        step();
        raddr1 = 3'd4; rf_rdata1 = 8'h12;
        #1;
        check("fwd1_nowen", 32'(fwd_rdata1), 32'h12);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
